// File: rtl/nib_rx.sv
`default_nettype none
// ============================================================================
//  Module   : nib_rx
//  Purpose  : Serial nibble receiver. Recovers 4-bit frames from an
//             asynchronous, idle-high serial line:
//                start(0), d0..d3 (LSB first), [even parity], stop(1)
//             A good frame updates D and pulses LD for one cycle. A parity
//             error pulses PE, and a low stop bit pulses FE. After a framing
//             error the receiver waits for the line to return high before it
//             looks for a new start bit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BIT_DIV   : clock cycles per serial bit (even, 2..256)
//    PARITY_EN : 1 = frame carries an even-parity bit, 0 = no parity bit
//  Ports
//    CK   in   1  clock, rising edge
//    CLR  in   1  asynchronous active-high reset
//    RXD  in   1  serial line (asynchronous to CK, idle high)
//    D    out  4  last good received nibble
//    LD   out  1  one-cycle strobe: D is new and valid
//    PE   out  1  one-cycle strobe: parity error
//    FE   out  1  one-cycle strobe: framing error (stop bit sampled low)
//    BUSY out  1  high whenever the receiver is not idle
// ============================================================================
module nib_rx #(
   parameter int BIT_DIV   = 4,
   parameter int PARITY_EN = 1
) (
   input  logic       CK,
   input  logic       CLR,
   input  logic       RXD,
   output logic [3:0] D,
   output logic       LD,
   output logic       PE,
   output logic       FE,
   output logic       BUSY
);

   localparam int CW = $clog2(BIT_DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(BIT_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BIT_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PAR    = 3'd3,
      S_STOP   = 3'd4,
      S_WAITHI = 3'd5
   } state_t;

   // -------------------------------------------------------------------------
   // Two-flop synchronizer. Both flops reset to the idle level, so a reset
   // never manufactures a start bit.
   // -------------------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;
   logic rxs;

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= RXD;
         sync2_q <= sync1_q;
      end
   end

   assign rxs = sync2_q;

   // -------------------------------------------------------------------------
   // Receive FSM and registered outputs
   // -------------------------------------------------------------------------
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    idx_q;
   logic [3:0]    sh_q;
   logic          perr_q;
   logic [3:0]    d_q;
   logic          ld_q;
   logic          pe_q;
   logic          fe_q;
   logic          busy_q;

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         sh_q    <= 4'd0;
         perr_q  <= 1'b0;
         d_q     <= 4'd0;
         ld_q    <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // Strobes are single-cycle: cleared every cycle unless re-asserted.
         ld_q <= 1'b0;
         pe_q <= 1'b0;
         fe_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
                  perr_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end

            // Re-check the line at mid start bit to reject glitches.
            S_START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q <= '0;
                  if (!rxs) begin
                     state_q <= S_DATA;
                     idx_q   <= 2'd0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // From here on every sample lands one full bit period after the
            // previous one, i.e. at the middle of each bit.
            S_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q       <= '0;
                  sh_q[idx_q] <= rxs;
                  idx_q       <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q <= (PARITY_EN != 0) ? S_PAR : S_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // Even parity: data bits plus parity bit must XOR to zero.
            S_PAR: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  perr_q  <= (PARITY_EN != 0) && (rxs ^ (^sh_q));
                  state_q <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // A low stop bit takes priority over a parity error: the frame
            // boundary itself is unreliable, so only FE is reported.
            S_STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q <= '0;
                  if (rxs) begin
                     if (!perr_q) begin
                        d_q  <= sh_q;
                        ld_q <= 1'b1;
                     end else begin
                        pe_q <= 1'b1;
                     end
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     fe_q    <= 1'b1;
                     state_q <= S_WAITHI;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // A line stuck low after a framing error (e.g. break) must not be
            // mistaken for a stream of start bits.
            S_WAITHI: begin
               if (rxs) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign D    = d_q;
   assign LD   = ld_q;
   assign PE   = pe_q;
   assign FE   = fe_q;
   assign BUSY = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nib_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nib_rx
//  Purpose  : Self-checking bench for nib_rx (BIT_DIV=4, PARITY_EN=1).
//             Table of frames with expected strobes and D, plus directed
//             sequences for latency, break/WAITHI, glitch, back-to-back
//             frames and mid-frame reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nib_rx;

   localparam int BD = 4;

   logic       CK;
   logic       CLR;
   logic       RXD;
   logic [3:0] D;
   logic       LD;
   logic       PE;
   logic       FE;
   logic       BUSY;

   nib_rx #(.BIT_DIV(BD), .PARITY_EN(1)) dut (
      .CK   (CK),
      .CLR  (CLR),
      .RXD  (RXD),
      .D    (D),
      .LD   (LD),
      .PE   (PE),
      .FE   (FE),
      .BUSY (BUSY)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // ------------------------------------------------------------------------
   // Output monitor (negedge sampling)
   // ------------------------------------------------------------------------
   int         cyc = 0;
   int         ld_n = 0, pe_n = 0, fe_n = 0, busy_n = 0;
   int         ld_cyc = 0;
   int         bad_strobe = 0;
   logic       prev_strobe = 1'b0;
   logic [3:0] d_log[$];

   always @(posedge CK) cyc++;

   always @(negedge CK) begin
      int s;
      s = int'(LD) + int'(PE) + int'(FE);
      if (LD) begin
         ld_n++;
         ld_cyc = cyc;
         d_log.push_back(D);
      end
      if (PE)   pe_n++;
      if (FE)   fe_n++;
      if (BUSY) busy_n++;
      if (s > 1 || (s != 0 && prev_strobe)) bad_strobe++;
      prev_strobe = (s != 0);
   end

   // ------------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      RXD = b;
      repeat (BD) @(negedge CK);
   endtask

   // Caller must be at a negedge.
   task automatic send_frame(input logic [3:0] data, input logic pflip,
                             input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(data[i]);
      send_bit((^data) ^ pflip);
      send_bit(stop);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (BUSY && k < 80) begin
         @(negedge CK);
         k++;
      end
      if (k >= 80) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: BUSY still 1 after %0d cycles, expected 0", name, k);
      end
   endtask

   // ------------------------------------------------------------------------
   // Frame table
   // ------------------------------------------------------------------------
   typedef struct {
      logic [3:0] data;
      logic       pflip;
      logic       stop;
      int         exp_ld;
      int         exp_pe;
      int         exp_fe;
      logic [3:0] exp_d;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int b_ld, b_pe, b_fe, b_busy, base, t0;

      //          data   pflip stop  ld pe fe  D
      vecs[0] = '{4'hA, 1'b0, 1'b1, 1, 0, 0, 4'hA};
      vecs[1] = '{4'hA, 1'b1, 1'b1, 0, 1, 0, 4'hA};
      vecs[2] = '{4'h5, 1'b0, 1'b0, 0, 0, 1, 4'hA};
      vecs[3] = '{4'h3, 1'b1, 1'b0, 0, 0, 1, 4'hA};  // FE masks PE
      vecs[4] = '{4'h0, 1'b0, 1'b1, 1, 0, 0, 4'h0};
      vecs[5] = '{4'hF, 1'b0, 1'b1, 1, 0, 0, 4'hF};
      vecs[6] = '{4'h7, 1'b0, 1'b1, 1, 0, 0, 4'h7};
      vecs[7] = '{4'h7, 1'b1, 1'b1, 0, 1, 0, 4'h7};
      vecs[8] = '{4'h1, 1'b0, 1'b1, 1, 0, 0, 4'h1};
      vecs[9] = '{4'h8, 1'b1, 1'b1, 0, 1, 0, 4'h1};

      // ---------------- reset state ----------------
      CLR = 1'b1;
      RXD = 1'b1;
      repeat (3) @(negedge CK);
      chk("rst_D", int'(D), 0);
      chk("rst_LD", int'(LD), 0);
      chk("rst_PE", int'(PE), 0);
      chk("rst_FE", int'(FE), 0);
      chk("rst_BUSY", int'(BUSY), 0);
      CLR = 1'b0;
      repeat (4) @(negedge CK);

      // ---------------- LD latency ----------------
      b_ld = ld_n;
      t0   = cyc;
      send_frame(4'h9, 1'b0, 1'b1);
      wait_idle("lat_idle");
      repeat (3) @(negedge CK);
      chk("lat_ld_count", ld_n - b_ld, 1);
      chk("lat_cycles_27_to_29", ((ld_cyc - t0) >= 27 && (ld_cyc - t0) <= 29) ? 1 : 0, 1);
      chk("lat_D", int'(D), 9);

      // ---------------- table-driven frames ----------------
      for (int i = 0; i < 10; i++) begin
         b_ld = ld_n;
         b_pe = pe_n;
         b_fe = fe_n;
         send_frame(vecs[i].data, vecs[i].pflip, vecs[i].stop);
         RXD = 1'b1;
         wait_idle($sformatf("vec%0d_idle", i));
         repeat (3) @(negedge CK);
         chk($sformatf("vec%0d_LD", i), ld_n - b_ld, vecs[i].exp_ld);
         chk($sformatf("vec%0d_PE", i), pe_n - b_pe, vecs[i].exp_pe);
         chk($sformatf("vec%0d_FE", i), fe_n - b_fe, vecs[i].exp_fe);
         chk($sformatf("vec%0d_D", i), int'(D), int'(vecs[i].exp_d));
      end

      // ---------------- break: stop low, line held low ----------------
      b_ld = ld_n;
      b_pe = pe_n;
      b_fe = fe_n;
      send_frame(4'h5, 1'b0, 1'b0);
      repeat (10) @(negedge CK);
      chk("brk_FE", fe_n - b_fe, 1);
      chk("brk_BUSY_held", int'(BUSY), 1);
      RXD = 1'b1;
      wait_idle("brk_idle");
      repeat (20) @(negedge CK);
      chk("brk_LD", ld_n - b_ld, 0);
      chk("brk_FE_once", fe_n - b_fe, 1);
      chk("brk_PE", pe_n - b_pe, 0);
      chk("brk_BUSY_end", int'(BUSY), 0);
      chk("brk_D", int'(D), 1);

      // ---------------- one-cycle glitch ----------------
      b_ld   = ld_n;
      b_pe   = pe_n;
      b_fe   = fe_n;
      b_busy = busy_n;
      RXD = 1'b0;
      @(negedge CK);
      RXD = 1'b1;
      repeat (12) @(negedge CK);
      chk("glitch_busy_cycles", busy_n - b_busy, 2);
      chk("glitch_strobes", (ld_n - b_ld) + (pe_n - b_pe) + (fe_n - b_fe), 0);

      // ---------------- back-to-back frames ----------------
      base = d_log.size();
      b_ld = ld_n;
      send_frame(4'h3, 1'b0, 1'b1);
      send_frame(4'hC, 1'b0, 1'b1);
      wait_idle("b2b_idle");
      repeat (3) @(negedge CK);
      chk("b2b_ld_count", ld_n - b_ld, 2);
      chk("b2b_first_D", (d_log.size() > base) ? int'(d_log[base]) : -1, 3);
      chk("b2b_second_D", (d_log.size() > base + 1) ? int'(d_log[base + 1]) : -1, 12);

      // ---------------- reset mid-frame ----------------
      send_bit(1'b0);
      send_bit(1'b1);
      RXD = 1'b1;
      repeat (2) @(negedge CK);
      CLR = 1'b1;
      #1;
      chk("clr_D", int'(D), 0);
      chk("clr_LD", int'(LD), 0);
      chk("clr_PE", int'(PE), 0);
      chk("clr_FE", int'(FE), 0);
      chk("clr_BUSY", int'(BUSY), 0);
      @(negedge CK);
      @(negedge CK);
      CLR = 1'b0;
      b_busy = busy_n;
      b_ld   = ld_n;
      b_pe   = pe_n;
      b_fe   = fe_n;
      repeat (12) @(negedge CK);
      chk("clr_no_resume", busy_n - b_busy, 0);
      send_frame(4'h6, 1'b0, 1'b1);
      wait_idle("clr_idle");
      repeat (3) @(negedge CK);
      chk("clr_next_LD", ld_n - b_ld, 1);
      chk("clr_next_errs", (pe_n - b_pe) + (fe_n - b_fe), 0);
      chk("clr_next_D", int'(D), 6);

      // ---------------- strobe exclusivity over the whole run ----------------
      chk("strobe_exclusive", bad_strobe, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
